// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencing controller for the 6-stage core
//
// Purpose: merges ID/EX/MEM stall requests into the per-stage stall vector,
// sequences exception/ERET redirection (IDLE -> FREEZE -> FLUSH -> REFILL) and
// flags stalls that persist for MAX_STALL consecutive cycles.
//
// Optional feature macro: PIPE_CTRL_PERF_EN (adds perf_stall_cycles / perf_flush_count).
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-low reset
//   stallreq_id    in   ID stage hold request
//   stallreq_ex    in   EX stage hold request
//   stallreq_mem   in   MEM stage hold request (data bus wait)
//   excepttype_i   in   exception code from MEM, 0 = none
//   cp0_epc_i      in   EPC, sampled together with the exception
//   stall          out  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB, 1 = hold
//   flush          out  one-cycle flush pulse
//   new_pc         out  redirect target, meaningful while flush = 1
//   busy           out  sequencer not idle
//   stall_timeout  out  sticky watchdog flag
//   perf_stall_cycles / perf_flush_count  out  (PIPE_CTRL_PERF_EN only)

module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter logic [31:0] ERET_CODE     = 32'h0000_000E,
    parameter int unsigned REFILL_CYCLES = 3,
    parameter int unsigned MAX_STALL     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        busy,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] perf_stall_cycles,
    output logic [15:0] perf_flush_count,
`endif
    output logic        stall_timeout
);

    localparam logic [3:0]  REFILL_W = 4'(REFILL_CYCLES);
    localparam logic [15:0] MAX_W    = 16'(MAX_STALL);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FREEZE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_REFILL = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [3:0]  refill_q, refill_d;
    logic [15:0] wdog_q, wdog_d;
    logic        timeout_q, timeout_d;

    logic [5:0]  req_stall;
    logic [5:0]  stall_c;
    logic        flush_c;

    // Highest requester wins: a MEM hold also freezes everything upstream.
    always_comb begin
        req_stall = 6'b000000;
        if (stallreq_mem) begin
            req_stall = 6'b011111;
        end else if (stallreq_ex) begin
            req_stall = 6'b001111;
        end else if (stallreq_id) begin
            req_stall = 6'b000111;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        new_pc_d = new_pc_q;
        refill_d = refill_q;
        stall_c  = 6'b000000;
        flush_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (excepttype_i != 32'd0) begin
                    // Hold MEM/WB so the faulting instruction never retires.
                    stall_c  = 6'b011111;
                    target_d = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
                    state_d  = ST_FREEZE;
                end else begin
                    stall_c = req_stall;
                end
            end
            ST_FREEZE: begin
                // Publish the target only now so new_pc is stable outside FLUSH.
                new_pc_d = target_q;
                state_d  = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush_c  = 1'b1;
                refill_d = REFILL_W;
                state_d  = ST_REFILL;
            end
            ST_REFILL: begin
                stall_c = req_stall;
                // Only stall-free cycles count toward the refill window.
                if (req_stall == 6'b000000) begin
                    if (refill_q <= 4'd1) begin
                        refill_d = 4'd0;
                        state_d  = ST_IDLE;
                    end else begin
                        refill_d = refill_q - 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Watchdog: counts consecutive stalled cycles, saturating at MAX_STALL.
    always_comb begin
        if ((stall_c == 6'b000000) || flush_c) begin
            wdog_d = 16'd0;
        end else if (wdog_q < MAX_W) begin
            wdog_d = wdog_q + 16'd1;
        end else begin
            wdog_d = wdog_q;
        end
        // Visible during the stall cycle that reaches the limit, then sticky.
        timeout_d = timeout_q | (wdog_d == MAX_W);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            target_q  <= 32'd0;
            new_pc_q  <= 32'd0;
            refill_q  <= 4'd0;
            wdog_q    <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            new_pc_q  <= new_pc_d;
            refill_q  <= refill_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    // Combinational outputs are gated so they read as reset values while rst is low.
    assign stall         = rst ? stall_c : 6'b000000;
    assign flush         = rst & flush_c;
    assign stall_timeout = rst & timeout_d;
    assign new_pc        = new_pc_q;
    assign busy          = (state_q != ST_IDLE);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [15:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 16'd0;
        end else begin
            if (stall_c != 6'b000000) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush_c) begin
                perf_flush_q <= perf_flush_q + 16'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed table-driven bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        busy;
    logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [15:0] perf_flush_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_ctrl #(
        .EXC_VECTOR   (32'h0000_0020),
        .ERET_CODE    (32'h0000_000E),
        .REFILL_CYCLES(3),
        .MAX_STALL    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excepttype_i (excepttype_i),
        .cp0_epc_i    (cp0_epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .busy         (busy),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_count (perf_flush_count),
`endif
        .stall_timeout(stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    typedef struct {
        logic        id, ex, mem;
        logic [31:0] exc, epc;
        logic [5:0]  st;
        logic        fl, bz, chk_pc;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic id, input logic ex, input logic mem,
                       input logic [31:0] exc, input logic [31:0] epc,
                       input logic [5:0] st, input logic fl, input logic bz,
                       input logic chk_pc, input logic [31:0] pc);
        vec_t v;
        v.id = id; v.ex = ex; v.mem = mem; v.exc = exc; v.epc = epc;
        v.st = st; v.fl = fl; v.bz = bz; v.chk_pc = chk_pc; v.pc = pc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h, required %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic id, input logic ex, input logic mem,
                         input logic [31:0] exc, input logic [31:0] epc);
        stallreq_id  = id;
        stallreq_ex  = ex;
        stallreq_mem = mem;
        excepttype_i = exc;
        cp0_epc_i    = epc;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("reset_stall",   -1, 32'(stall), 32'h0);
        chk("reset_flush",   -1, 32'(flush), 32'h0);
        chk("reset_new_pc",  -1, new_pc, 32'h0);
        chk("reset_busy",    -1, 32'(busy), 32'h0);
        chk("reset_timeout", -1, 32'(stall_timeout), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        //   id ex mem exc         epc           stall      fl bz chk pc
        add(0, 0, 0, 0,           0,            6'b000000, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 1, 0, 0,       0,            6'b001111, 0, 0, 0, 0);
        add(0, 0, 0, 0,           0,            6'b000000, 0, 0, 0, 0);
        add(1, 1, 1, 0,           0,            6'b011111, 0, 0, 0, 0);
        add(1, 1, 0, 0,           0,            6'b001111, 0, 0, 0, 0);
        add(1, 0, 0, 0,           0,            6'b000111, 0, 0, 0, 0);
        add(0, 0, 0, 0,           0,            6'b000000, 0, 0, 0, 0);
        // exception with a pending MEM stall
        add(0, 0, 1, 32'h1,       0,            6'b011111, 0, 0, 0, 0);
        add(0, 0, 1, 0,           0,            6'b000000, 0, 1, 0, 0);
        add(0, 0, 1, 0,           0,            6'b000000, 1, 1, 1, 32'h20);
        add(0, 0, 0, 0,           0,            6'b000000, 0, 1, 0, 0);
        add(0, 0, 1, 0,           0,            6'b011111, 0, 1, 0, 0);
        add(0, 0, 0, 0,           0,            6'b000000, 0, 1, 0, 0);
        add(0, 0, 0, 0,           0,            6'b000000, 0, 1, 0, 0);
        add(0, 0, 0, 0,           0,            6'b000000, 0, 0, 0, 0);
        // ERET: N, second at N+3 ignored, repeat at N+6 accepted
        add(0, 0, 0, 32'hE,       32'hBFC00100, 6'b011111, 0, 0, 0, 0);
        add(0, 0, 0, 0,           0,            6'b000000, 0, 1, 0, 0);
        add(0, 0, 0, 0,           0,            6'b000000, 1, 1, 1, 32'hBFC00100);
        add(0, 0, 0, 32'hE,       32'h00001234, 6'b000000, 0, 1, 0, 0);
        add(0, 0, 0, 0,           0,            6'b000000, 0, 1, 0, 0);
        add(0, 0, 0, 0,           0,            6'b000000, 0, 1, 0, 0);
        add(0, 0, 0, 32'hE,       32'hBFC00100, 6'b011111, 0, 0, 0, 0);
        add(0, 0, 0, 0,           0,            6'b000000, 0, 1, 0, 0);
        add(1, 1, 1, 0,           0,            6'b000000, 1, 1, 1, 32'hBFC00100);
        add(0, 0, 0, 0,           0,            6'b000000, 0, 1, 0, 0);
        add(0, 0, 0, 0,           0,            6'b000000, 0, 1, 0, 0);
        add(0, 0, 0, 0,           0,            6'b000000, 0, 1, 0, 0);
        add(0, 0, 0, 0,           0,            6'b000000, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].id, tbl[i].ex, tbl[i].mem, tbl[i].exc, tbl[i].epc);
            #1;
            chk("stall",   i, 32'(stall), 32'(tbl[i].st));
            chk("flush",   i, 32'(flush), 32'(tbl[i].fl));
            chk("busy",    i, 32'(busy),  32'(tbl[i].bz));
            chk("timeout", i, 32'(stall_timeout), 32'h0);
            if (tbl[i].chk_pc) chk("new_pc", i, new_pc, tbl[i].pc);
        end

        // Watchdog with MAX_STALL = 8: rises during the 8th stalled cycle, sticky.
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            drive(0, 0, 1, 0, 0);
            #1;
            chk("wdog_stall",   100 + k, 32'(stall), 32'h1F);
            chk("wdog_timeout", 100 + k, 32'(stall_timeout), (k == 8) ? 32'h1 : 32'h0);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0);
            #1;
            chk("wdog_sticky", 110 + k, 32'(stall_timeout), 32'h1);
            chk("wdog_stall0", 110 + k, 32'(stall), 32'h0);
        end
        #2 rst = 1'b0;
        #1;
        chk("wdog_reset_clear", 120, 32'(stall_timeout), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("wdog_after_reset", 121, 32'(stall_timeout), 32'h0);

        // Reset asserted while in FLUSH: everything clears, redirect is discarded.
        @(negedge clk);
        drive(0, 0, 0, 32'h1, 0);
        #1;
        chk("rf_exc_stall", 130, 32'(stall), 32'h1F);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1;
        chk("rf_freeze_busy", 131, 32'(busy), 32'h1);
        @(negedge clk);
        drive(0, 0, 1, 0, 0);
        #1;
        chk("rf_flush", 132, 32'(flush), 32'h1);
        chk("rf_new_pc", 132, new_pc, 32'h20);
        #2 rst = 1'b0;
        #1;
        chk("rf_rst_flush",  133, 32'(flush), 32'h0);
        chk("rf_rst_stall",  133, 32'(stall), 32'h0);
        chk("rf_rst_busy",   133, 32'(busy), 32'h0);
        chk("rf_rst_new_pc", 133, new_pc, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk("rf_post_flush", 140 + k, 32'(flush), 32'h0);
            chk("rf_post_busy",  140 + k, 32'(busy), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
